// File: rtl/regfile_write_bank_pkg.sv
// Shared constants and FSM encodings for the register-file write bank.
package regfile_write_bank_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_write_bank_decoder_5to32.sv
// Combinational one-hot decoder with enable: dec_o = en_i ? (1 << sel_i) : 0.
module decoder_5to32
  import regfile_write_bank_pkg::*;
#(
  parameter int unsigned SEL_W = REG_ADDR_W,
  parameter int unsigned OUT_W = REG_COUNT
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [OUT_W-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      dec_o[i] = en_i && (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Register-file storage with a valid/ready write port and a sequential bulk-clear sweep.
module regfile_write_bank
  import regfile_write_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = REG_WIDTH,
  parameter int unsigned NUM_REGS = REG_COUNT,
  parameter int unsigned ADDR_W   = REG_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic                      clear_req_i,
  output logic                      clear_busy_o,
  output logic                      clear_done_o,
  output logic [NUM_REGS*WIDTH-1:0] reg_flat_o
);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  logic                wr_en;
  logic [NUM_REGS-1:0] wr_dec, sw_dec, reg_we;
  logic [WIDTH-1:0]    wdata;
  logic                unused_we0;

  assign wr_ready_o   = (state_q == ST_IDLE);
  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = done_q;
  assign wr_en        = wr_valid_i && wr_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        // Requests arriving mid-sweep are dropped; the sweep never restarts.
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  decoder_5to32 #(
    .SEL_W (ADDR_W),
    .OUT_W (NUM_REGS)
  ) u_wr_dec (
    .en_i  (wr_en),
    .sel_i (wr_addr_i),
    .dec_o (wr_dec)
  );

  decoder_5to32 #(
    .SEL_W (ADDR_W),
    .OUT_W (NUM_REGS)
  ) u_sw_dec (
    .en_i  (clear_busy_o),
    .sel_i (cnt_q),
    .dec_o (sw_dec)
  );

  // wr_en is already gated off in CLEAR, so the sweep wins by construction.
  assign reg_we     = wr_dec | sw_dec;
  assign wdata      = clear_busy_o ? '0 : wr_data_i;
  assign unused_we0 = reg_we[0];

  assign reg_flat_o[WIDTH-1:0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic [WIDTH-1:0] reg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        reg_q <= '0;
      end else if (reg_we[i]) begin
        reg_q <= wdata;
      end
    end

    assign reg_flat_o[i*WIDTH +: WIDTH] = reg_q;
  end

endmodule
